// File: rtl/mem_arb_pkg.sv
// Shared encodings for the main-memory arbiter: grant state (also driven on owner)
// and the requester IDs used for the last-served record.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the single main-memory port: instruction-side and
// data-side miss paths. Holds a grant until m_ready and counts conflict cycles.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int D_PRIO = 1,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [AW-1:0] i_a,
    input  logic          i_access,
    output logic [DW-1:0] i_d_r,
    output logic          i_ready,
    input  logic [AW-1:0] d_a,
    input  logic [DW-1:0] d_d_w,
    input  logic          d_access,
    input  logic          d_write,
    output logic [DW-1:0] d_d_r,
    output logic          d_ready,
    output logic [AW-1:0] m_a,
    output logic [DW-1:0] m_d_w,
    output logic          m_access,
    output logic          m_write,
    input  logic [DW-1:0] m_d_r,
    input  logic          m_ready,
    output logic [1:0]    owner,
    output logic [CW-1:0] conflict_cnt
);

    arb_state_t state;
    logic       last_srv;
    logic       conflict;

    // Only one side is ever granted, so two live requests always leave one waiting.
    assign conflict = i_access && d_access;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state        <= IDLE;
            last_srv     <= REQ_I;
            conflict_cnt <= '0;
        end else begin
            if (conflict && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (i_access && d_access)
                        state <= ((D_PRIO != 0) || (last_srv == REQ_I)) ? GNT_D : GNT_I;
                    else if (i_access)
                        state <= GNT_I;
                    else if (d_access)
                        state <= GNT_D;
                end
                // Completion wins over abort; the owner's own access on the
                // completion cycle is not a new request.
                GNT_I: begin
                    if (m_ready) begin
                        last_srv <= REQ_I;
                        state    <= d_access ? GNT_D : IDLE;
                    end else if (!i_access) begin
                        state <= IDLE;
                    end
                end
                GNT_D: begin
                    if (m_ready) begin
                        last_srv <= REQ_D;
                        state    <= i_access ? GNT_I : IDLE;
                    end else if (!d_access) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_access = 1'b0;
        m_write  = 1'b0;
        m_a      = '0;
        m_d_w    = '0;
        i_ready  = 1'b0;
        i_d_r    = '0;
        d_ready  = 1'b0;
        d_d_r    = '0;
        case (state)
            GNT_I: begin
                m_access = 1'b1;
                m_a      = i_a;
                i_ready  = m_ready;
                i_d_r    = m_d_r;
            end
            GNT_D: begin
                m_access = 1'b1;
                m_a      = d_a;
                m_write  = d_write;
                m_d_w    = d_d_w;
                d_ready  = m_ready;
                d_d_r    = m_d_r;
            end
            default: ;
        endcase
    end

    assign owner = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter share one stimulus;
// expected ready responses are queued per DUT and popped by ready monitors.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] i_a, d_a, d_d_w, m_d_r;
    logic        i_access, d_access, d_write, m_ready;

    logic [31:0] p_i_d_r, p_d_d_r, p_m_a, p_m_d_w;
    logic        p_i_ready, p_d_ready, p_m_access, p_m_write;
    logic [1:0]  p_owner;
    logic [15:0] p_cnt;
    logic [31:0] r_i_d_r, r_d_d_r, r_m_a, r_m_d_w;
    logic        r_i_ready, r_d_ready, r_m_access, r_m_write;
    logic [1:0]  r_owner;
    logic [15:0] r_cnt;

    typedef struct {
        bit          side;
        logic [31:0] data;
    } exp_t;

    exp_t q_p[$];
    exp_t q_r[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .D_PRIO(1), .CW(16)) dut_p (
        .clk(clk), .clrn(clrn),
        .i_a(i_a), .i_access(i_access), .i_d_r(p_i_d_r), .i_ready(p_i_ready),
        .d_a(d_a), .d_d_w(d_d_w), .d_access(d_access), .d_write(d_write),
        .d_d_r(p_d_d_r), .d_ready(p_d_ready),
        .m_a(p_m_a), .m_d_w(p_m_d_w), .m_access(p_m_access), .m_write(p_m_write),
        .m_d_r(m_d_r), .m_ready(m_ready), .owner(p_owner), .conflict_cnt(p_cnt)
    );

    mem_bus_arbiter #(.AW(32), .DW(32), .D_PRIO(0), .CW(16)) dut_r (
        .clk(clk), .clrn(clrn),
        .i_a(i_a), .i_access(i_access), .i_d_r(r_i_d_r), .i_ready(r_i_ready),
        .d_a(d_a), .d_d_w(d_d_w), .d_access(d_access), .d_write(d_write),
        .d_d_r(r_d_d_r), .d_ready(r_d_ready),
        .m_a(r_m_a), .m_d_w(r_m_d_w), .m_access(r_m_access), .m_write(r_m_write),
        .m_d_r(m_d_r), .m_ready(m_ready), .owner(r_owner), .conflict_cnt(r_cnt)
    );

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk2(string nm, logic [63:0] ap, logic [63:0] ar, logic [63:0] exp);
        check({"p_", nm}, ap, exp);
        check({"r_", nm}, ar, exp);
    endtask

    task automatic push(bit side, logic [31:0] data);
        exp_t e;
        e.side = side;
        e.data = data;
        q_p.push_back(e);
        q_r.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_p
        exp_t e;
        if (p_i_ready || p_d_ready) begin
            check("p_dual_ready", {63'd0, p_i_ready & p_d_ready}, 64'd0);
            if (q_p.size() == 0) begin
                check("p_unexpected_ready", 64'd1, 64'd0);
            end else begin
                e = q_p.pop_front();
                check("p_resp_side", {63'd0, p_d_ready}, {63'd0, e.side});
                check("p_resp_data", {32'd0, p_d_ready ? p_d_d_r : p_i_d_r}, {32'd0, e.data});
            end
        end
    end

    always @(negedge clk) begin : mon_r
        exp_t e;
        if (r_i_ready || r_d_ready) begin
            check("r_dual_ready", {63'd0, r_i_ready & r_d_ready}, 64'd0);
            if (q_r.size() == 0) begin
                check("r_unexpected_ready", 64'd1, 64'd0);
            end else begin
                e = q_r.pop_front();
                check("r_resp_side", {63'd0, r_d_ready}, {63'd0, e.side});
                check("r_resp_data", {32'd0, r_d_ready ? r_d_d_r : r_i_d_r}, {32'd0, e.data});
            end
        end
    end

    initial begin
        clrn = 1'b0; i_a = '0; d_a = '0; d_d_w = '0; m_d_r = '0;
        i_access = 1'b0; d_access = 1'b0; d_write = 1'b0; m_ready = 1'b0;
        tick();
        tick();
        chk2("rst_m_access", p_m_access, r_m_access, 0);
        chk2("rst_m_a", p_m_a, r_m_a, 0);
        check("p_rst_m_d_w", p_m_d_w, 0);
        check("p_rst_m_write", p_m_write, 0);
        chk2("rst_owner", p_owner, r_owner, 0);
        chk2("rst_cnt", p_cnt, r_cnt, 0);
        clrn = 1'b1;

        // instruction read, memory answers three cycles after the request
        i_access = 1'b1; i_a = 32'h0000_0148;
        push(1'b0, 32'h3C01_0000);
        tick();
        chk2("i_m_access", p_m_access, r_m_access, 1);
        check("p_i_m_a", p_m_a, 32'h148);
        check("p_i_m_write", p_m_write, 0);
        chk2("i_owner", p_owner, r_owner, 2'b01);
        tick();
        tick();
        m_ready = 1'b1; m_d_r = 32'h3C01_0000;
        tick();
        m_ready = 1'b0; m_d_r = '0; i_access = 1'b0;
        chk2("i_done_owner", p_owner, r_owner, 2'b00);
        check("p_i_ready_low", p_i_ready, 0);

        // data write
        d_access = 1'b1; d_write = 1'b1; d_a = 32'h2000; d_d_w = 32'hDEAD_BEEF;
        push(1'b1, 32'h1111_1111);
        tick();
        check("p_d_m_write", p_m_write, 1);
        check("p_d_m_d_w", p_m_d_w, 32'hDEAD_BEEF);
        check("p_d_m_a", p_m_a, 32'h2000);
        chk2("d_owner", p_owner, r_owner, 2'b10);
        tick();
        m_ready = 1'b1; m_d_r = 32'h1111_1111;
        #1;
        check("p_d_i_ready_low", p_i_ready, 0);
        tick();
        m_ready = 1'b0; m_d_r = '0; d_access = 1'b0; d_write = 1'b0;
        chk2("d_done_owner", p_owner, r_owner, 2'b00);

        // last served is D: priority DUT picks D, round-robin picks I; then reset mid-grant
        i_access = 1'b1; i_a = 32'h500; d_access = 1'b1; d_a = 32'h600;
        tick();
        check("p_prio_owner", p_owner, 2'b10);
        check("r_rr_owner", r_owner, 2'b01);
        tick();
        chk2("conflict_2", p_cnt, r_cnt, 2);
        clrn = 1'b0;
        tick();
        clrn = 1'b1; i_access = 1'b0; d_access = 1'b0;
        chk2("rst_mid_m_access", p_m_access, r_m_access, 0);
        chk2("rst_mid_owner", p_owner, r_owner, 0);
        chk2("rst_mid_cnt", p_cnt, r_cnt, 0);
        m_ready = 1'b1; m_d_r = 32'h999;
        #1;
        check("p_rst_no_d_ready", p_d_ready, 0);
        tick();
        m_ready = 1'b0; m_d_r = '0;

        // simultaneous requests after reset: D first, I handed over with no bubble
        d_access = 1'b1; d_a = 32'h40; i_access = 1'b1; i_a = 32'h80;
        push(1'b1, 32'hAAAA_0001);
        push(1'b0, 32'hBBBB_0002);
        tick();
        chk2("both_first_owner", p_owner, r_owner, 2'b10);
        tick();
        m_ready = 1'b1; m_d_r = 32'hAAAA_0001;
        tick();
        m_ready = 1'b0; m_d_r = '0; d_access = 1'b0;
        chk2("handover_owner", p_owner, r_owner, 2'b01);
        check("p_handover_m_a", p_m_a, 32'h80);
        chk2("conflict_3", p_cnt, r_cnt, 3);
        tick();
        m_ready = 1'b1; m_d_r = 32'hBBBB_0002;
        tick();
        m_ready = 1'b0; m_d_r = '0; i_access = 1'b0;
        chk2("handover_done_owner", p_owner, r_owner, 2'b00);

        // continuous re-request from both sides alternates D, I, D, I, D, I
        i_access = 1'b1; d_access = 1'b1; i_a = 32'h700; d_a = 32'h800;
        tick();
        for (int k = 0; k < 6; k++) begin
            check("r_alt_owner", r_owner, (k % 2 == 0) ? 2'b10 : 2'b01);
            check("p_alt_owner", p_owner, (k % 2 == 0) ? 2'b10 : 2'b01);
            push((k % 2 == 0), 32'h5000_0000 + k);
            m_ready = 1'b1; m_d_r = 32'h5000_0000 + k;
            tick();
            m_ready = 1'b0; m_d_r = '0;
        end
        i_access = 1'b0; d_access = 1'b0;
        tick();
        chk2("alt_abort_owner", p_owner, r_owner, 2'b00);

        // abort from GNT_I, then m_ready in IDLE is ignored
        i_access = 1'b1; i_a = 32'h300;
        tick();
        chk2("abort_grant", p_owner, r_owner, 2'b01);
        i_access = 1'b0;
        tick();
        chk2("abort_owner", p_owner, r_owner, 2'b00);
        chk2("abort_m_access", p_m_access, r_m_access, 0);
        m_ready = 1'b1; m_d_r = 32'h1234;
        #1;
        chk2("idle_no_i_ready", p_i_ready, r_i_ready, 0);
        tick();
        m_ready = 1'b0; m_d_r = '0;

        // conflict counter saturation
        clrn = 1'b0;
        tick();
        clrn = 1'b1; i_access = 1'b1; d_access = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk2("cnt_fffe", p_cnt, r_cnt, 16'hFFFE);
        repeat (7) @(posedge clk);
        #1;
        chk2("cnt_sat", p_cnt, r_cnt, 16'hFFFF);
        i_access = 1'b0; d_access = 1'b0;

        repeat (3) tick();
        check("p_queue_empty", q_p.size(), 0);
        check("r_queue_empty", q_r.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single word-wide main-memory port (m_a, m_d_r, m_d_w, m_access, m_write, m_ready) between the instruction cache/TLB miss path and the data cache/TLB miss path.
- Grants one requester at a time and holds the grant until memory returns m_ready.
- Routes m_ready and read data back to the owner only.
- Counts arbitration conflicts for performance debug.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- D_PRIO, 1, 1 = data side has fixed priority on conflict; 0 = round-robin.
- CW, 16, conflict counter width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clrn  in  1  synchronous active-low reset, sampled on rising edge of clk.
- i_a  in  AW  instruction-side word address.
- i_access  in  1  instruction-side request; held with i_a stable until i_ready.
- i_d_r  out  DW  read data to the instruction side.
- i_ready  out  1  instruction-side transfer complete (one-cycle pulse).
- d_a  in  AW  data-side word address.
- d_d_w  in  DW  data-side write data.
- d_access  in  1  data-side request; held with d_a/d_d_w/d_write stable until d_ready.
- d_write  in  1  data-side write (1) or read (0).
- d_d_r  out  DW  read data to the data side.
- d_ready  out  1  data-side transfer complete (one-cycle pulse).
- m_a  out  AW  memory address.
- m_d_w  out  DW  memory write data.
- m_access  out  1  memory request.
- m_write  out  1  memory write enable.
- m_d_r  in  DW  memory read data.
- m_ready  in  1  memory transfer complete.
- owner  out  2  current grant: 00 none, 01 I, 10 D.
- conflict_cnt  out  CW  saturating count of conflict cycles.

Behaviour:
- State machine, registered state: IDLE, GNT_I, GNT_D. There is no combinational grant.
- Reset (clrn=0 at an edge):
  - state=IDLE, last-served=I, conflict_cnt=0.
  - Resulting outputs: m_access=0, m_write=0, m_a=0, m_d_w=0, i_ready=d_ready=0, i_d_r=d_d_r=0, owner=00.
  - Reset mid-transaction abandons it; m_access is low from the first cycle after that edge.
- IDLE transitions:
  - Only i_access=1: go to GNT_I.
  - Only d_access=1: go to GNT_D.
  - Both requesting, D_PRIO=1: go to GNT_D.
  - Both requesting, D_PRIO=0: grant the side not in last-served. After reset that is D.
  - Neither requesting: stay in IDLE.
- Arbitration latency: a request seen in IDLE gives m_access=1 in the next cycle.
- GNT_I outputs:
  - m_access=1, m_a=i_a, m_write=0, m_d_w=0.
  - i_ready=m_ready and i_d_r=m_d_r, combinational pass-through.
  - d_ready=0, d_d_r=0.
- GNT_D outputs:
  - m_access=1, m_a=d_a, m_write=d_write, m_d_w=d_d_w.
  - d_ready=m_ready and d_d_r=m_d_r, combinational pass-through.
  - i_ready=0, i_d_r=0.
- IDLE outputs: all m_* outputs and ready/data outputs are 0.
- Completion (m_ready=1 in GNT_x):
  - last-served is set to x.
  - If the other side's access=1 in that cycle, hand over directly to GNT_other with no bubble.
  - Otherwise go to IDLE.
  - The owner's own access in the completion cycle is never treated as a new request. A requester re-requesting always passes through one IDLE cycle.
- Abort: in GNT_x with x_access=0 and m_ready=0, go to IDLE and leave last-served unchanged. Memory sees m_access drop the next cycle.
- m_ready while in IDLE is ignored; no ready is generated.
- conflict_cnt increments by 1 in each cycle where both i_access=1 and d_access=1 and at least one requester is not granted. It saturates at 2^CW-1 and does not wrap.
- owner reflects the registered state.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE=2'b00, GNT_I=2'b01, GNT_D=2'b10, also used for owner;
  - requester-ID constants REQ_I and REQ_D.
- No sub-module: the state machine, output muxes and counter are all in one module (about 150 lines).

Test Plan:
- Reset, then i_access=1 with i_a=0x00000148; memory asserts m_ready 3 cycles later with m_d_r=0x3C010000 -> m_access rises 1 cycle after the request with m_a=0x148 and m_write=0; i_ready pulses exactly 1 cycle with i_d_r=0x3C010000; owner goes 01 then 00.
- d_access=1, d_write=1, d_a=0x2000, d_d_w=0xDEADBEEF -> m_write=1, m_d_w=0xDEADBEEF, d_ready pulses on m_ready, i_ready stays 0.
- D_PRIO=1, both request in the same cycle -> GNT_D first. The I request is served back-to-back at the D completion edge with no IDLE cycle. conflict_cnt counts every cycle in which I was left waiting.
- D_PRIO=0, both requesters continuously re-request for 3 transactions each -> grants alternate D, I, D, I, D, I. Neither side is granted twice in a row while the other waits.
- Assert clrn=0 while in GNT_D before m_ready -> next cycle m_access=0 and owner=00; a following m_ready pulse gives no d_ready.
- Drop i_access while in GNT_I with m_ready=0 -> IDLE next cycle; a later m_ready in IDLE produces no i_ready. Drive 2^CW+5 conflict cycles -> conflict_cnt holds at 0xFFFF.
